prog_seq_ctrl: RTL

Run controller that sequences the fetch unit through the three course programs. It receives a start request from the testbench and holds the fetch unit in init. It then forces the PC to the selected program's start address, times the run until the fetch unit raises Halt, reports completion with a handshake, and advances ProgState. It sits at the top level between the testbench and the IF stage. Its forced-jump outputs are muxed ahead of the datapath branch.

---
 rtl/prog_seq_pkg.sv | 33 +++
 rtl/prog_seq_ctrl_if.sv | 47 ++++
 rtl/prog_seq_ctrl_sat_counter.sv | 29 ++
 rtl/prog_seq_ctrl.sv | 132 +++++++++++++
 4 files changed

// File: rtl/prog_seq_pkg.sv
// Shared types and constants for the program run sequencer.
// Program entry points are fixed by the course program images.
package prog_seq_pkg;

   localparam int NUM_PROGS_DEF   = 3;
   localparam int PC_W_DEF        = 10;
   localparam int CYC_W_DEF       = 16;
   localparam int INIT_CYCLES_DEF = 2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_RUN,
      ST_DONE,
      ST_FINISH
   } state_t;

   localparam logic [PC_W_DEF-1:0] START_ADDR [NUM_PROGS_DEF] = '{
      10'h000,
      10'h0C0,
      10'h180
   };

   // Out-of-range program indices fall back to program 0.
   function automatic logic [PC_W_DEF-1:0] start_addr(input logic [1:0] prog);
      case (prog)
         2'd1:    start_addr = START_ADDR[1];
         2'd2:    start_addr = START_ADDR[2];
         default: start_addr = START_ADDR[0];
      endcase
   endfunction

endpackage

// File: rtl/prog_seq_ctrl_if.sv
// Handshake and fetch-control bundle between the testbench, the sequencer and the IF stage.
interface prog_seq_ctrl_if #(
   parameter int PC_W  = 10,
   parameter int CYC_W = 16
);

   logic             Req;
   logic             Halt;
   logic             FetchInit;
   logic             LoadPC;
   logic [PC_W-1:0]  LoadTarget;
   logic [1:0]       ProgState;
   logic             Busy;
   logic             Ack;
   logic             TimedOut;
   logic [CYC_W-1:0] CycleCount;
   logic             AllDone;

   modport master (
      output Req,
      output Halt,
      input  FetchInit,
      input  LoadPC,
      input  LoadTarget,
      input  ProgState,
      input  Busy,
      input  Ack,
      input  TimedOut,
      input  CycleCount,
      input  AllDone
   );

   modport slave (
      input  Req,
      input  Halt,
      output FetchInit,
      output LoadPC,
      output LoadTarget,
      output ProgState,
      output Busy,
      output Ack,
      output TimedOut,
      output CycleCount,
      output AllDone
   );

endinterface

// File: rtl/prog_seq_ctrl_sat_counter.sv
// Run-length counter: clears to zero, counts while enabled, sticks at all-ones.
module sat_counter #(
   parameter int CYC_W = 16
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_clear,
   input  logic             i_enable,
   output logic [CYC_W-1:0] o_count,
   output logic             o_sat
);

   logic [CYC_W-1:0] r_count;
   logic             w_sat;

   assign w_sat = &r_count;

   always_ff @(posedge i_clk) begin
      if (i_rst || i_clear) begin
         r_count <= '0;
      end else if (i_enable && !w_sat) begin
         r_count <= r_count + CYC_W'(1);
      end
   end

   assign o_count = r_count;
   assign o_sat   = w_sat;

endmodule

// File: rtl/prog_seq_ctrl.sv
// Run controller: holds IF in init, forces the PC to each program's entry point,
// times the run until Halt (or counter saturation) and hands completion back via Req/Ack.
//
// state  | meaning
// IDLE   | IF frozen, waiting for Req
// LOAD   | IF frozen INIT_CYCLES cycles, then one forced-jump cycle
// RUN    | IF running, CycleCount counting until Halt or saturation
// DONE   | IF frozen, Ack high until Req drops
// FINISH | all programs complete, only Init leaves
module prog_seq_ctrl
   import prog_seq_pkg::*;
#(
   parameter int NUM_PROGS   = NUM_PROGS_DEF,
   parameter int PC_W        = PC_W_DEF,
   parameter int CYC_W       = CYC_W_DEF,
   parameter int INIT_CYCLES = INIT_CYCLES_DEF
) (
   input logic            CLK,
   input logic            Init,
   prog_seq_ctrl_if.slave bus
);

   localparam int LD_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES + 1) : 1;

   state_t           r_state;
   logic [LD_W-1:0]  r_load_cnt;
   logic             r_fetch_init;
   logic             r_load_pc;
   logic [PC_W-1:0]  r_load_target;
   logic [1:0]       r_prog;
   logic             r_busy;
   logic             r_ack;
   logic             r_timed_out;
   logic             r_all_done;

   logic             w_cnt_clear;
   logic             w_cnt_enable;
   logic [CYC_W-1:0] w_cycle_count;
   logic             w_cnt_sat;

   // Counter sees Req/Halt directly but its output is still a register.
   assign w_cnt_clear  = (r_state == ST_IDLE) && bus.Req;
   assign w_cnt_enable = (r_state == ST_RUN) && !bus.Halt;

   sat_counter #(
      .CYC_W (CYC_W)
   ) u_sat_counter (
      .i_clk    (CLK),
      .i_rst    (Init),
      .i_clear  (w_cnt_clear),
      .i_enable (w_cnt_enable),
      .o_count  (w_cycle_count),
      .o_sat    (w_cnt_sat)
   );

   always_ff @(posedge CLK) begin
      if (Init) begin
         r_state       <= ST_IDLE;
         r_load_cnt    <= '0;
         r_fetch_init  <= 1'b1;
         r_load_pc     <= 1'b0;
         r_load_target <= PC_W'(start_addr(2'd0));
         r_prog        <= 2'd0;
         r_busy        <= 1'b0;
         r_ack         <= 1'b0;
         r_timed_out   <= 1'b0;
         r_all_done    <= 1'b0;
      end else begin
         r_load_pc <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (bus.Req) begin
                  r_state     <= ST_LOAD;
                  r_busy      <= 1'b1;
                  r_timed_out <= 1'b0;
                  r_load_cnt  <= LD_W'(INIT_CYCLES - 1);
               end
            end
            ST_LOAD: begin
               if (r_load_pc) begin
                  r_state <= ST_RUN;
               end else if (r_load_cnt == '0) begin
                  r_load_pc    <= 1'b1;
                  r_fetch_init <= 1'b0;
               end else begin
                  r_load_cnt <= r_load_cnt - LD_W'(1);
               end
            end
            ST_RUN: begin
               // Halt has priority over saturation on the same edge.
               if (bus.Halt || w_cnt_sat) begin
                  r_state      <= ST_DONE;
                  r_fetch_init <= 1'b1;
                  r_busy       <= 1'b0;
                  r_ack        <= 1'b1;
                  r_timed_out  <= !bus.Halt;
               end
            end
            ST_DONE: begin
               if (!bus.Req) begin
                  r_ack <= 1'b0;
                  if (r_prog < 2'(NUM_PROGS - 1)) begin
                     r_state       <= ST_IDLE;
                     r_prog        <= r_prog + 2'd1;
                     r_load_target <= PC_W'(start_addr(r_prog + 2'd1));
                  end else begin
                     r_state    <= ST_FINISH;
                     r_all_done <= 1'b1;
                  end
               end
            end
            ST_FINISH: begin
               r_state <= ST_FINISH;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.FetchInit  = r_fetch_init;
   assign bus.LoadPC     = r_load_pc;
   assign bus.LoadTarget = r_load_target;
   assign bus.ProgState  = r_prog;
   assign bus.Busy       = r_busy;
   assign bus.Ack        = r_ack;
   assign bus.TimedOut   = r_timed_out;
   assign bus.CycleCount = w_cycle_count;
   assign bus.AllDone    = r_all_done;

endmodule
